// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account datapath.
// - Opcode constants for the transaction port (3-bit opcode field).
// - State codes used by the ATM control FSM that drives this datapath.
// - Datapath widths.
// - Reset images for the PIN and balance stores. These are the
//   contents of the account database and are fixed at elaboration.
package atm_pkg;

  localparam int ACC_W = 4;
  localparam int PIN_W = 16;
  localparam int BAL_W = 32;

  localparam logic [2:0] OP_BALANCE    = 3'd3;
  localparam logic [2:0] OP_WITHDRAW   = 3'd4;
  localparam logic [2:0] OP_DEPOSIT    = 3'd5;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd6;

  typedef enum logic [2:0] {
    WAITING        = 3'd0,
    AUTHENTICATION = 3'd1,
    MENU           = 3'd2,
    IDLE           = 3'd7
  } atm_state_e;

  // Reset PIN of account idx: 16'hA000 | idx.
  function automatic logic [PIN_W-1:0] pin_init(input int idx);
    return PIN_W'(32'hA000 + idx);
  endfunction

  // Reset balance of account idx: 500 * idx.
  function automatic logic [BAL_W-1:0] bal_init(input int idx);
    return BAL_W'(idx * 500);
  endfunction

endpackage

// File: rtl/atm_account_core_if.sv
// Request/response bundle between the ATM control FSM (master) and the
// account datapath (slave).
// - master drives: acc_num, pin, new_pin, amount, operation, op_valid
// - slave drives : acc_index, acc_found, acc_auth, balance, success, done
interface atm_account_core_if;
  import atm_pkg::*;

  logic [ACC_W-1:0] acc_num;
  logic [PIN_W-1:0] pin;
  logic [PIN_W-1:0] new_pin;
  logic [BAL_W-1:0] amount;
  logic [2:0]       operation;
  logic             op_valid;

  logic [ACC_W-1:0] acc_index;
  logic             acc_found;
  logic             acc_auth;
  logic [BAL_W-1:0] balance;
  logic             success;
  logic             done;

  modport master (
    output acc_num, pin, new_pin, amount, operation, op_valid,
    input  acc_index, acc_found, acc_auth, balance, success, done
  );

  modport slave (
    input  acc_num, pin, new_pin, amount, operation, op_valid,
    output acc_index, acc_found, acc_auth, balance, success, done
  );

endinterface

// File: rtl/atm_pin_store.sv
// PIN store and account lookup.
// - clk, rst     : clock, asynchronous active-low reset
// - acc_num, pin : card account number and entered PIN
// - wr_en/wr_pin : PIN write into the currently looked-up account
// - acc_index    : acc_num when the account exists, else 0
// - acc_found    : acc_num < NUM_ACCOUNTS
// - acc_auth     : acc_found and pin matches the stored PIN
module atm_pin_store
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic             wr_en,
  input  logic [PIN_W-1:0] wr_pin,
  output logic [ACC_W-1:0] acc_index,
  output logic             acc_found,
  output logic             acc_auth
);

  logic [PIN_W-1:0] pin_db [NUM_ACCOUNTS];

  assign acc_found = int'(acc_num) < NUM_ACCOUNTS;
  assign acc_index = acc_found ? acc_num : '0;
  assign acc_auth  = acc_found && (pin == pin_db[acc_index]);

  // One register per account so each entry can be reloaded from the
  // database image on reset; only the looked-up entry is written.
  generate
    for (genvar gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_pin
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pin_db[gi] <= pin_init(gi);
        end else if (wr_en && (acc_index == ACC_W'(gi))) begin
          pin_db[gi] <= wr_pin;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/atm_account_core.sv
// Account datapath for the ATM: balance store, transaction decode and
// the success/done result registers. PIN store and lookup live in
// atm_pin_store.
// - clk, rst : clock, asynchronous active-low reset
// - bus      : slave side of the request/response bundle
// A request strobed with op_valid completes in one cycle: store writes,
// success and done all update on the sampling edge.
module atm_account_core
  import atm_pkg::*;
#(
  parameter int NUM_ACCOUNTS = 10
) (
  input  logic                clk,
  input  logic                rst,
  atm_account_core_if.slave   bus
);

  logic [BAL_W-1:0] bal_db [NUM_ACCOUNTS];

  logic [ACC_W-1:0] acc_index;
  logic             acc_found;
  logic             acc_auth;
  logic [BAL_W-1:0] cur_bal;

  logic             bal_wr_en;
  logic [BAL_W-1:0] bal_wr_data;
  logic             pin_wr_en;
  logic             success_next;
  logic [BAL_W:0]   dep_sum;

  logic             success_reg;
  logic             done_reg;

  atm_pin_store #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS)
  ) u_pin_store (
    .clk       (clk),
    .rst       (rst),
    .acc_num   (bus.acc_num),
    .pin       (bus.pin),
    .wr_en     (pin_wr_en),
    .wr_pin    (bus.new_pin),
    .acc_index (acc_index),
    .acc_found (acc_found),
    .acc_auth  (acc_auth)
  );

  assign cur_bal = acc_found ? bal_db[acc_index] : '0;

  // Extra bit catches deposit overflow.
  assign dep_sum = {1'b0, cur_bal} + {1'b0, bus.amount};

  // Transaction decode. Writes are qualified with op_valid so the stores
  // only move on an accepted request; unauthorised requests fall through
  // with success_next = 0.
  always_comb begin
    bal_wr_en    = 1'b0;
    bal_wr_data  = cur_bal;
    pin_wr_en    = 1'b0;
    success_next = 1'b0;
    if (acc_auth) begin
      case (bus.operation)
        OP_BALANCE: begin
          success_next = 1'b1;
        end
        OP_WITHDRAW: begin
          if (bus.amount <= cur_bal) begin
            bal_wr_en    = bus.op_valid;
            bal_wr_data  = cur_bal - bus.amount;
            success_next = 1'b1;
          end
        end
        OP_DEPOSIT: begin
          if (!dep_sum[BAL_W]) begin
            bal_wr_en    = bus.op_valid;
            bal_wr_data  = dep_sum[BAL_W-1:0];
            success_next = 1'b1;
          end
        end
        OP_CHANGE_PIN: begin
          pin_wr_en    = bus.op_valid;
          success_next = 1'b1;
        end
        default: begin
          success_next = 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_bal
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          bal_db[gi] <= bal_init(gi);
        end else if (bal_wr_en && (acc_index == ACC_W'(gi))) begin
          bal_db[gi] <= bal_wr_data;
        end
      end
    end
  endgenerate

  // Reset clears done, so a request in flight at reset never completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_reg    <= 1'b0;
      success_reg <= 1'b0;
    end else begin
      done_reg <= bus.op_valid;
      if (bus.op_valid) begin
        success_reg <= success_next;
      end
    end
  end

  assign bus.acc_index = acc_index;
  assign bus.acc_found = acc_found;
  assign bus.acc_auth  = acc_auth;
  assign bus.balance   = cur_bal;
  assign bus.success   = success_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_atm_account_core.sv
// Self-checking bench for atm_account_core: directed cases followed by a
// randomized run against a behavioural account model.
module tb_atm_account_core;

  localparam int N = 10;

  logic clk;
  logic rst;

  atm_account_core_if bus ();

  atm_account_core #(
    .NUM_ACCOUNTS (N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain arrays of PINs and balances.
  logic [15:0] m_pin [N];
  logic [31:0] m_bal [N];
  logic        m_success;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pin[i] = 16'hA000 | 16'(i);
      m_bal[i] = 32'(i * 500);
    end
    m_success = 1'b0;
  endtask

  task automatic model_op(input int acc, input logic [15:0] p, input logic [2:0] op,
                          input logic [31:0] amt, input logic [15:0] np, output logic ok);
    logic [63:0] s;
    ok = 1'b0;
    if (acc < N && p == m_pin[acc]) begin
      case (op)
        3'd3: ok = 1'b1;
        3'd4: if (amt <= m_bal[acc]) begin m_bal[acc] = m_bal[acc] - amt; ok = 1'b1; end
        3'd5: begin
          s = {32'b0, m_bal[acc]} + {32'b0, amt};
          if (s <= 64'hFFFF_FFFF) begin m_bal[acc] = s[31:0]; ok = 1'b1; end
        end
        3'd6: begin m_pin[acc] = np; ok = 1'b1; end
        default: ok = 1'b0;
      endcase
    end
  endtask

  // Check combinational lookup outputs against the model for current inputs.
  task automatic chk_lookup(input string tag);
    int a;
    logic f, au;
    a  = int'(bus.acc_num);
    f  = a < N;
    au = f && (bus.pin == m_pin[a < N ? a : 0]);
    chk({tag, ".found"}, 64'(bus.acc_found), 64'(f));
    chk({tag, ".auth"},  64'(bus.acc_auth),  64'(au));
    chk({tag, ".index"}, 64'(bus.acc_index), f ? 64'(a) : 64'd0);
    chk({tag, ".bal"},   64'(bus.balance),   f ? 64'(m_bal[a]) : 64'd0);
  endtask

  task automatic set_in(input int acc, input logic [15:0] p, input logic [2:0] op,
                        input logic [31:0] amt, input logic [15:0] np, input logic v);
    bus.acc_num   = 4'(acc);
    bus.pin       = p;
    bus.operation = op;
    bus.amount    = amt;
    bus.new_pin   = np;
    bus.op_valid  = v;
  endtask

  // One isolated request: drive at negedge, sampled at posedge, result
  // checked one negedge later with op_valid dropped.
  task automatic do_op(input string tag, input int acc, input logic [15:0] p, input logic [2:0] op,
                       input logic [31:0] amt, input logic [15:0] np);
    logic ok;
    @(negedge clk);
    set_in(acc, p, op, amt, np, 1'b1);
    #1;
    chk_lookup({tag, ".pre"});
    model_op(acc, p, op, amt, np, ok);
    m_success = ok;
    @(negedge clk);
    bus.op_valid = 1'b0;
    #1;
    chk({tag, ".done"},    64'(bus.done),    64'd1);
    chk({tag, ".success"}, 64'(bus.success), 64'(m_success));
    chk_lookup({tag, ".post"});
    $display("txn %s acc=%0d op=%0d amt=%0h success=%0b bal=%0h", tag, acc, op, amt, bus.success, bus.balance);
  endtask

  initial begin
    logic ok;
    logic pending;
    logic [15:0] rp;
    logic [31:0] ra;
    int ra_acc;
    logic [2:0] rop;
    logic rv;

    model_reset();
    set_in(0, 16'h0, 3'd0, 32'h0, 16'h0, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.done",    64'(bus.done),    64'd0);
    chk("reset.success", 64'(bus.success), 64'd0);
    rst = 1'b1;

    // Lookup: account 2, right and wrong PIN
    @(negedge clk);
    set_in(2, m_pin[2], 3'd3, 32'h0, 16'h0, 1'b0);
    #1;
    chk_lookup("lookup2");
    chk("lookup2.bal_init", 64'(bus.balance), 64'd1000);
    bus.pin = 16'hBEEF;
    #1;
    chk("lookup2.wrongpin", 64'(bus.acc_auth), 64'd0);

    // Nonexistent account
    set_in(12, 16'hA00C, 3'd4, 32'd1, 16'h0, 1'b0);
    #1;
    chk_lookup("lookup12");
    do_op("wd_noacc", 12, 16'hA00C, 3'd4, 32'd1, 16'h0);

    do_op("wd300",    2, m_pin[2], 3'd4, 32'd300, 16'h0);
    chk("wd300.bal", 64'(bus.balance), 64'd700);
    do_op("wd701",    2, m_pin[2], 3'd4, 32'd701, 16'h0);
    do_op("dep50",    2, m_pin[2], 3'd5, 32'd50,  16'h0);
    chk("dep50.bal", 64'(bus.balance), 64'd750);
    do_op("dep_top",  2, m_pin[2], 3'd5, 32'hFFFF_FFF0 - 32'd750, 16'h0);
    do_op("dep_ovf",  2, m_pin[2], 3'd5, 32'h20, 16'h0);
    chk("dep_ovf.bal", 64'(bus.balance), 64'hFFFF_FFF0);
    do_op("dep_max",  2, m_pin[2], 3'd5, 32'hF, 16'h0);
    do_op("dep_ovf1", 2, m_pin[2], 3'd5, 32'h1, 16'h0);
    do_op("wd_all",   2, m_pin[2], 3'd4, 32'hFFFF_FFFF, 16'h0);
    do_op("bal_q",    5, m_pin[5], 3'd3, 32'h0, 16'h0);
    do_op("badpin",   5, 16'h0000, 3'd3, 32'h0, 16'h0);
    do_op("wd_zero",  0, m_pin[0], 3'd4, 32'h0, 16'h0);

    // Change PIN, then old/new PIN lookups
    do_op("chpin", 3, m_pin[3], 3'd6, 32'h0, 16'h1234);
    bus.pin = 16'hA003;
    #1;
    chk("chpin.oldpin", 64'(bus.acc_auth), 64'd0);
    bus.pin = 16'h1234;
    #1;
    chk("chpin.newpin", 64'(bus.acc_auth), 64'd1);

    // Randomized run, op_valid often back-to-back
    pending = 1'b0;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      #1;
      if (pending) begin
        chk("rnd.done",    64'(bus.done),    64'd1);
        chk("rnd.success", 64'(bus.success), 64'(m_success));
        chk_lookup("rnd.post");
      end else begin
        chk("rnd.idle_done",    64'(bus.done),    64'd0);
        chk("rnd.idle_success", 64'(bus.success), 64'(m_success));
      end
      ra_acc = int'($urandom_range(0, 13));
      rp  = ($urandom_range(0, 3) != 0 && ra_acc < N) ? m_pin[ra_acc] : 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'($urandom_range(0, 2000));
        2: ra = (ra_acc < N) ? m_bal[ra_acc] : 32'd0;
        default: ra = (ra_acc < N) ? ~m_bal[ra_acc] : 32'd1;
      endcase
      rv = ($urandom_range(0, 3) != 0);
      set_in(ra_acc, rp, rop, ra, 16'($urandom), rv);
      #1;
      chk_lookup("rnd.pre");
      if (rv) begin
        model_op(ra_acc, rp, rop, ra, bus.new_pin, ok);
        m_success = ok;
      end
      pending = rv;
      if (rv) $display("txn rnd%0d acc=%0d op=%0d amt=%0h", it, ra_acc, rop, ra);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    #1;
    if (pending) chk("rnd.last_done", 64'(bus.done), 64'd1);
    chk("rnd.last_success", 64'(bus.success), 64'(m_success));

    // Completed withdraw, then a second one cut off by asynchronous reset
    do_op("wd_prerst", 4, m_pin[4], 3'd4, 32'd10, 16'h0);
    @(negedge clk);
    set_in(4, m_pin[4], 3'd4, 32'd10, 16'h0, 1'b1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst.done_async",    64'(bus.done),    64'd0);
    chk("arst.success_async", 64'(bus.success), 64'd0);
    chk("arst.bal_async",     64'(bus.balance), 64'd2000);
    @(negedge clk);
    bus.op_valid = 1'b0;
    #1;
    chk("arst.done",    64'(bus.done),    64'd0);
    chk("arst.success", 64'(bus.success), 64'd0);
    chk_lookup("arst");
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("arst.nodone", 64'(bus.done), 64'd0);

    do_op("illegal7", 4, m_pin[4], 3'd7, 32'd10, 16'h0);
    do_op("illegal0", 4, m_pin[4], 3'd0, 32'd10, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
